// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state encoding and elaboration helpers shared by the reset sequencer.
package rst_seq_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_ASSERT = 2'd0;
  localparam state_t ST_SOFT   = 2'd1;
  localparam state_t ST_SEQ    = 2'd2;
  localparam state_t ST_DONE   = 2'd3;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/rst_sync_cell.sv
// rst_sync_cell: async-assert, sync-deassert reset synchroniser producing rst_sync.
module rst_sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic rst_sync
);
  // chain[0] takes the release edge itself; the STAGES flops behind it settle metastability
  logic [STAGES:0] chain;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) chain <= '0;
    else chain <= {chain[STAGES-1:0], 1'b1};
  assign rst_sync = chain[STAGES];
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staggered per-channel reset release with clock-gate window and soft-reset rerun.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int GATE_ON     = 5,
  parameter int GATE_OFF    = 18,
  parameter int REL_BASE    = 11,
  parameter int REL_STEP    = 2,
  parameter int SOFT_HOLD   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sw_rst_req_i,
  output logic [NUM_CH-1:0] ch_rst_n_o,
  output logic              gate_clk_o,
  output logic              seq_done_o,
  output logic              sw_rst_ack_o
);
  localparam int LAST   = max2(GATE_OFF, REL_BASE + (NUM_CH - 1) * REL_STEP);
  localparam int HOLD_W = $clog2(SOFT_HOLD + 1);
  localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(LAST);
  localparam logic [CNT_W-1:0]  ON_C   = CNT_W'(GATE_ON);
  localparam logic [CNT_W-1:0]  OFF_C  = CNT_W'(GATE_OFF);
  localparam logic [CNT_W-1:0]  ONE_C  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_C = HOLD_W'(SOFT_HOLD);
  if (LAST > 2 ** CNT_W - 1) begin : g_chk_cnt
    $error("rst_seq_ctrl: CNT_W=%0d cannot hold LAST=%0d", CNT_W, LAST);
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("rst_seq_ctrl: SYNC_STAGES must be >= 2");
  end
  if (GATE_OFF <= GATE_ON || REL_BASE <= GATE_ON) begin : g_chk_order
    $error("rst_seq_ctrl: GATE_OFF and REL_BASE must exceed GATE_ON");
  end
  if (SOFT_HOLD < 1) begin : g_chk_hold
    $error("rst_seq_ctrl: SOFT_HOLD must be >= 1");
  end
  state_t            state, nxt_state;
  logic [CNT_W-1:0]  cnt, nxt_cnt;
  logic [HOLD_W-1:0] hold, nxt_hold;
  logic [NUM_CH-1:0] nxt_ch;
  logic              rst_sync, req_q, req_rise, live;
  rst_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .rst_sync (rst_sync)
  );
  assign req_rise = sw_rst_req_i & ~req_q;
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_hold  = '0;
    case (state)
      ST_ASSERT: begin
        nxt_state = rst_sync ? ST_SEQ : ST_ASSERT;
        nxt_cnt   = rst_sync ? ONE_C : '0;
      end
      ST_SEQ: begin
        nxt_cnt   = cnt >= LAST_C ? LAST_C : cnt + 1'b1;
        nxt_state = nxt_cnt == LAST_C ? ST_DONE : ST_SEQ;
      end
      ST_DONE: begin
        nxt_state = req_rise ? ST_SOFT : ST_DONE;
        nxt_cnt   = req_rise ? '0 : LAST_C;
      end
      default: begin
        nxt_state = hold == HOLD_C ? ST_SEQ : ST_SOFT;
        nxt_cnt   = hold == HOLD_C ? ONE_C : '0;
        nxt_hold  = hold + 1'b1;
      end
    endcase
  end
  // outputs decode the next state so they move on the same edge as cnt
  assign live = nxt_state == ST_SEQ || nxt_state == ST_DONE;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] TH = CNT_W'(REL_BASE + i * REL_STEP);
    assign nxt_ch[i] = live && nxt_cnt >= TH;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= ST_ASSERT;
      cnt          <= '0;
      hold         <= '0;
      req_q        <= 1'b0;
      ch_rst_n_o   <= '0;
      gate_clk_o   <= 1'b0;
      seq_done_o   <= 1'b0;
      sw_rst_ack_o <= 1'b0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      hold         <= nxt_hold;
      req_q        <= sw_rst_req_i;
      ch_rst_n_o   <= nxt_ch;
      gate_clk_o   <= live && nxt_cnt >= ON_C && nxt_cnt < OFF_C;
      seq_done_o   <= nxt_state == ST_DONE;
      sw_rst_ack_o <= state == ST_DONE && req_rise;
    end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed timeline checks plus random req/reset traffic against an edge-count model.
module tb_rst_seq_ctrl;
  localparam int LAST = 18, LAST8 = 32, HOLD = 4;
  logic clk = 1'b0, reset_n = 1'b1, req = 1'b0;
  logic [3:0] ch;
  logic [7:0] ch8;
  logic gate, done, ack, gate8, done8, ack8;
  int n_chk = 0, n_err = 0;
  int edge_n = -1, seq_start = 3, rst_cnt = 0, rst_seen = 0, mc, mc8;
  bit req_prev = 1'b0, exp_ack = 1'b0, ack_prev = 1'b0;
  logic [3:0] ch_prev = '0;
  int ed[8] = '{6, 7, 12, 13, 15, 17, 19, 20};
  logic [3:0] ex_ch[8] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hf, 4'hf};
  logic [1:0] ex_gd[8] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
  always #5 clk = ~clk;
  rst_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .sw_rst_req_i(req), .ch_rst_n_o(ch),
    .gate_clk_o(gate), .seq_done_o(done), .sw_rst_ack_o(ack)
  );
  rst_seq_ctrl #(.NUM_CH(8), .REL_STEP(3), .GATE_OFF(20)) dut8 (
    .clk(clk), .reset_n(reset_n), .sw_rst_req_i(1'b0), .ch_rst_n_o(ch8),
    .gate_clk_o(gate8), .seq_done_o(done8), .sw_rst_ack_o(ack8)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int clampc(input int v, input int last);
    return v < 0 ? 0 : (v > last ? last : v);
  endfunction
  function automatic logic [31:0] exp_ch(input int c, input int n, input int step);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = c >= 11 + i * step;
    return r;
  endfunction
  // model: cnt is the number of edges since the sequence (re)started, clamped to LAST
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      edge_n = -1; seq_start = 3; req_prev = 1'b0; exp_ack = 1'b0; rst_cnt++;
    end else begin
      mc = clampc(edge_n - seq_start + 1, LAST);
      edge_n++;
      exp_ack = mc == LAST && req && !req_prev;
      if (exp_ack) seq_start = edge_n + HOLD + 1;
      req_prev = req;
    end
  always @(negedge clk) begin
    mc  = clampc(edge_n - seq_start + 1, LAST);
    mc8 = clampc(edge_n - 2, LAST8);
    check("m_ch", 32'(ch), exp_ch(mc, 4, 2));
    check("m_gate", 32'(gate), 32'(mc >= 5 && mc < 18));
    check("m_done", 32'(done), 32'(mc == LAST));
    check("m_ack", 32'(ack), 32'(exp_ack));
    check("m8_ch", 32'(ch8), exp_ch(mc8, 8, 3));
    check("m8_gate", 32'(gate8), 32'(mc8 >= 5 && mc8 < 20));
    check("m8_done", 32'(done8), 32'(mc8 == LAST8));
    check("m8_ack", 32'(ack8), 32'(0));
    check("ch_order", 32'((ch >> 1) & ~ch), 32'(0));
    check("ack_width", 32'(ack & ack_prev), 32'(0));
    if (rst_cnt == rst_seen) check("ch_fall", 32'((ch_prev & ~ch) & {4{~ack}}), 32'(0));
    rst_seen = rst_cnt; ch_prev = ch; ack_prev = ack;
  end
  task automatic timeline(input string tag, input int last_e);
    int j = 0;
    for (int e = 0; e <= last_e; e++) begin
      @(negedge clk);
      if (j < 8 && e == ed[j]) begin
        check({tag, "_ch"}, 32'(ch), 32'(ex_ch[j]));
        check({tag, "_gate"}, 32'(gate), 32'(ex_gd[j][1]));
        check({tag, "_done"}, 32'(done), 32'(ex_gd[j][0]));
        j++;
      end
      if (e == 21) check({tag, "_gate8_on"}, 32'(gate8), 32'(1));
      if (e == 22) check({tag, "_gate8_off"}, 32'(gate8), 32'(0));
      if (e == 33) check({tag, "_ch8_7_pre"}, 32'(ch8[7]), 32'(0));
      if (e == 34) check({tag, "_ch8_7"}, 32'(ch8[7]), 32'(1));
      if (e == 34) check({tag, "_done8"}, 32'(done8), 32'(1));
    end
  endtask
  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ch", 32'(ch), 32'(0));
    check("rst_out", 32'({gate, done, ack}), 32'(0));
    reset_n = 1'b1;
    timeline("t1", 36);
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    repeat (15) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("t2_async_ch", 32'(ch), 32'(0));
    check("t2_async_out", 32'({gate, done, ack}), 32'(0));
    @(negedge clk) reset_n = 1'b1;
    timeline("t2", 21);
    repeat (2) @(negedge clk);
    req = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      @(negedge clk);
      if (e == 9) req = 1'b0;
      check("t3_ack", 32'(ack), 32'(e == 0));
      if (e <= HOLD) check("t3_hold", 32'({ch, gate, done}), 32'(0));
      if (e == 8 || e == 9) check("t3_gate", 32'(gate), 32'(e == 9));
      if (e == 21 || e == 22) check("t3_done", 32'(done), 32'(e == 22));
    end
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int e = 0; e <= 25; e++) begin
      @(negedge clk);
      if (e == 10) req = 1'b1;
      if (e == 11) req = 1'b0;
      check("t4_ack", 32'(ack), 32'(0));
      if (e >= 19) check("t4_done", 32'(done), 32'(e >= 20));
    end
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) req = ~req;
      if ($urandom_range(0, 199) == 0) begin
        #($urandom_range(1, 4)) reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
